// File: rtl/ppu_pkg.sv
// ppu_pkg
// Shared constants for the operand-select path: RV32I opcodes, the S-code
// values understood by the second-operand mux, the canonical NOP, and the
// decoded operand-select bundle type.
package ppu_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Operand-select codes; the second-operand mux decodes these same values
    localparam logic [2:0] SEL_PB    = 3'd0;
    localparam logic [2:0] SEL_IMM_I = 3'd1;
    localparam logic [2:0] SEL_IMM_S = 3'd2;
    localparam logic [2:0] SEL_IMM_U = 3'd3;
    localparam logic [2:0] SEL_PC    = 3'd4;
    localparam logic [2:0] SEL_ZERO  = 3'd5;

    // addi x0, x0, 0 -- treated as a bubble
    localparam logic [31:0] NOP = 32'h0000_0013;

    // One decoded entry as held in the skid FIFO
    typedef struct packed {
        logic [2:0]  s;
        logic [11:0] imm12_i;
        logic [11:0] imm12_s;
        logic [19:0] imm20;
        logic        illegal;
    } op_bundle_t;

endpackage

// File: rtl/operand_sel_decode.sv
// operand_sel_decode
// Purely combinational: maps an RV32I instruction word to its operand-select
// code, the raw I/S/U immediate fields and an illegal-opcode flag.
// Immediates are extracted unconditionally; sign extension happens in the mux.
// Ports:
//   instr  in  32  instruction word
//   bundle out     {s, imm12_i, imm12_s, imm20, illegal}
module operand_sel_decode
    import ppu_pkg::*;
(
    input  logic [31:0] instr,
    output op_bundle_t  bundle
);

    always_comb begin
        bundle         = '0;
        bundle.imm12_i = instr[31:20];
        bundle.imm12_s = {instr[31:25], instr[11:7]};
        bundle.imm20   = instr[31:12];
        unique case (instr[6:0])
            OP_R, OP_BRANCH:          bundle.s = SEL_PB;
            OP_IMM, OP_LOAD, OP_JALR: bundle.s = SEL_IMM_I;
            OP_STORE:                 bundle.s = SEL_IMM_S;
            OP_LUI, OP_AUIPC:         bundle.s = SEL_IMM_U;
            OP_JAL:                   bundle.s = SEL_PC;
            default: begin
                bundle.s       = SEL_ZERO;
                bundle.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/operand_select_decoder.sv
// operand_select_decoder
// Decode-stage block: accepts instructions over valid/ready, decodes the
// operand-select bundle and buffers it in a 2-entry skid FIFO so execute
// backpressure never makes fetch drop an instruction.
// Ports:
//   clk, reset (sync, active-high), flush (drop all buffered entries)
//   in_valid/in_instr/in_ready   upstream handshake
//   out_valid/out_ready          downstream handshake
//   S, imm12_I, imm12_S, imm20, illegal   head-entry payload (0 when empty)
module operand_select_decoder
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  S,
    output logic [11:0] imm12_I,
    output logic [11:0] imm12_S,
    output logic [19:0] imm20,
    output logic        illegal
);

    op_bundle_t       dec_bundle;
    op_bundle_t       head_bundle;
    op_bundle_t [1:0] mem_q, mem_d;
    logic       [1:0] count_q, count_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic             bubble;
    logic             push;
    logic             pop;

    operand_sel_decode u_decode (
        .instr  (in_instr),
        .bundle (dec_bundle)
    );

    // in_ready comes from registered count only (plus reset gating), so there
    // is no combinational path from out_ready back to fetch.
    assign in_ready  = ~reset & (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign bubble    = (in_instr == NOP);
    assign push      = in_valid & in_ready & ~bubble;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            // flush wins over push and pop
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (push) begin
                mem_d[tail_q] = dec_bundle;
                tail_d        = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '0;
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Payload reads zero whenever nothing is valid
    assign head_bundle = out_valid ? mem_q[head_q] : '0;
    assign S           = head_bundle.s;
    assign imm12_I     = head_bundle.imm12_i;
    assign imm12_S     = head_bundle.imm12_s;
    assign imm20       = head_bundle.imm20;
    assign illegal     = head_bundle.illegal;

endmodule

// File: tb/tb_operand_select_decoder.sv
// tb_operand_select_decoder
// Randomized and directed stimulus checked every cycle against a queue-based
// reference model, plus literal expectations for the documented scenarios.
module tb_operand_select_decoder;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  S;
    logic [11:0] imm12_I;
    logic [11:0] imm12_S;
    logic [19:0] imm20;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    // model entry: {S, imm12_I, imm12_S, imm20, illegal}
    logic [47:0] mq[$];

    operand_select_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .imm12_I   (imm12_I),
        .imm12_S   (imm12_S),
        .imm20     (imm20),
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] model_dec(input logic [31:0] w);
        logic [6:0] op;
        int sel;
        op  = w[6:0];
        if (op == 7'h33 || op == 7'h63)                     sel = 0;
        else if (op == 7'h13 || op == 7'h03 || op == 7'h67) sel = 1;
        else if (op == 7'h23)                               sel = 2;
        else if (op == 7'h37 || op == 7'h17)                sel = 3;
        else if (op == 7'h6F)                               sel = 4;
        else                                                sel = 5;
        return {sel[2:0], w[31:20], w[31:25], w[11:7], w[31:12], (sel == 5) ? 1'b1 : 1'b0};
    endfunction

    task automatic check_outputs();
        logic [47:0] exp;
        exp = (mq.size() > 0) ? mq[0] : 48'h0;
        chk("out_valid", {63'h0, out_valid}, {63'h0, (mq.size() > 0) ? 1'b1 : 1'b0});
        chk("payload", {16'h0, S, imm12_I, imm12_S, imm20, illegal}, {16'h0, exp});
    endtask

    // Drive one cycle of inputs at the negedge, check in_ready, advance the
    // model across the coming edge, then check registered outputs.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [31:0] ins, input logic ordy);
        bit do_push;
        reset = r; flush = f; in_valid = iv; in_instr = ins; out_ready = ordy;
        #1;
        chk("in_ready", {63'h0, in_ready}, {63'h0, (!r && mq.size() < 2) ? 1'b1 : 1'b0});
        if (r || f) begin
            mq.delete();
        end else begin
            do_push = iv && (mq.size() < 2) && (ins != 32'h0000_0013);
            if (mq.size() > 0 && ordy) void'(mq.pop_front());
            if (do_push) mq.push_back(model_dec(ins));
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [0:9];
        logic [31:0] w;
        int k;
        ops = '{7'h33, 7'h63, 7'h13, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h7F};
        k = $urandom_range(0, 99);
        w = $urandom;
        if (k < 20)      return 32'h0000_0013;
        else if (k < 85) return {w[31:7], ops[$urandom_range(0, 9)]};
        else             return w;
    endfunction

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("reset_out_valid", {63'h0, out_valid}, 64'h0);

        // basic decode
        cyc(0, 0, 1, 32'h0050_0093, 1);
        chk("addi_S", {61'h0, S}, 64'd1);
        chk("addi_imm12_I", {52'h0, imm12_I}, 64'h005);
        chk("addi_illegal", {63'h0, illegal}, 64'h0);
        cyc(0, 0, 1, 32'hFE11_2E23, 1);
        chk("sw_S", {61'h0, S}, 64'd2);
        chk("sw_imm12_S", {52'h0, imm12_S}, 64'hFFC);
        cyc(0, 0, 1, 32'h1234_50B7, 1);
        chk("lui_S", {61'h0, S}, 64'd3);
        chk("lui_imm20", {44'h0, imm20}, 64'h12345);
        cyc(0, 0, 1, 32'h0000_006F, 1);
        chk("jal_S", {61'h0, S}, 64'd4);
        cyc(0, 0, 1, 32'h0000_007F, 1);
        chk("bad_S", {61'h0, S}, 64'd5);
        chk("bad_illegal", {63'h0, illegal}, 64'h1);
        cyc(0, 0, 0, 0, 1);  // drain
        chk("drained", {63'h0, out_valid}, 64'h0);

        // bubble: accepted, never enqueued
        cyc(0, 0, 1, 32'h0000_0013, 1);
        chk("nop_no_output", {63'h0, out_valid}, 64'h0);

        // backpressure: A, B fill; C refused until a pop frees a slot
        cyc(0, 0, 1, 32'h0050_0093, 0);
        cyc(0, 0, 1, 32'hFE11_2E23, 0);
        cyc(0, 0, 1, 32'h1234_50B7, 0);  // refused, full
        chk("full_in_ready", {63'h0, in_ready}, 64'h0);
        chk("stall_head_A", {61'h0, S}, 64'd1);
        cyc(0, 0, 1, 32'h1234_50B7, 1);  // pop A, C still refused
        chk("head_B", {61'h0, S}, 64'd2);
        cyc(0, 0, 1, 32'h1234_50B7, 0);  // C accepted now
        chk("head_B_stable", {52'h0, imm12_S}, 64'hFFC);
        cyc(0, 0, 0, 0, 1);
        chk("head_C", {61'h0, S}, 64'd3);

        // flush priority with two entries buffered and a push in flight
        cyc(0, 0, 1, 32'h0000_006F, 0);  // now two entries
        cyc(0, 1, 1, 32'h0050_0093, 0);
        chk("flush_out_valid", {63'h0, out_valid}, 64'h0);
        chk("flush_S", {61'h0, S}, 64'h0);

        // reset mid-stream with one entry buffered
        cyc(0, 0, 1, 32'hFE11_2E23, 0);
        cyc(1, 0, 1, 32'h0050_0093, 0);
        chk("rst_in_ready_during", {63'h0, in_ready}, 64'h0);
        chk("rst_payload", {16'h0, out_valid, S, imm12_I, imm12_S, imm20, illegal}, 64'h0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_in_ready_after", {63'h0, in_ready}, 64'h1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                rand_instr(),
                ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_select_decoder.md
# operand_select_decoder

Decode-stage block producing the operand-select bundle that the second-operand multiplexer consumes: the 3-bit source code `S` plus the raw I-type, S-type and U-type immediate fields, together with an illegal-opcode flag. It accepts instruction words over a valid/ready handshake and buffers decoded results in a 2-entry skid FIFO. It sits between instruction fetch and the ID/EX boundary, so backpressure from the execute stage never forces fetch to drop an instruction.

## Interface
- Parameters: none. Widths are fixed by the RV32I format.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `flush  in  1`: discards all buffered entries (branch redirect).
- `in_valid  in  1`: `in_instr` is presented.
- `in_instr  in  32`: RV32I instruction word.
- `in_ready  out  1`: an entry is free (count < 2). Forced to 0 while `reset` is asserted.
- `out_valid  out  1`: head entry is valid.
- `out_ready  in  1`: consumer takes the head entry.
- `S  out  3`: operand-select code.
- `imm12_I  out  12`: instr[31:20].
- `imm12_S  out  12`: {instr[31:25], instr[11:7]}.
- `imm20  out  20`: instr[31:12].
- `illegal  out  1`: the opcode is not recognised.

## Operation
- Opcode decode (instr[6:0]) to `S` and `illegal`:
  - 0110011 (R-type) and 1100011 (branch): S=0, PB.
  - 0010011 (OP-IMM), 0000011 (load), 1100111 (JALR): S=1, I-immediate.
  - 0100011 (store): S=2, S-immediate.
  - 0110111 (LUI) and 0010111 (AUIPC): S=3, U-immediate.
  - 1101111 (JAL): S=4, PC.
  - Any other opcode: S=5, illegal=1.
- Immediate fields are always extracted, whatever the opcode; sign extension stays in the mux.
- Bubble: `in_instr` == 32'h0000_0013 (canonical NOP) is accepted but never enqueued.
- Skid FIFO:
  - Two entries of {S, imm12_I, imm12_S, imm20, illegal}, plus head pointer, tail pointer and a 2-bit count.
  - Push = `in_valid` & `in_ready` & ~bubble. Pop = `out_valid` & `out_ready`.
  - Simultaneous push and pop while full is impossible, because `in_ready` is 0 when full.
  - Simultaneous push and pop at count=1: count stays 1.
  - Pointers are 1 bit wide and wrap naturally.
- Outputs are driven from the head entry. While `out_valid` is 0, all payload outputs read 0.
- Flush: sets count to 0 and resets both pointers. Any push in the same cycle is dropped; a flush takes priority over push and pop.
- Reset: sets count to 0 and resets pointers; `out_valid`=0, `S`=0, all immediates 0, `illegal`=0. Reset mid-transfer discards the buffered contents.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears at the outputs after edge N (`out_valid`=1 in cycle N+1) when the FIFO was empty.
- Throughput is 1 instruction per cycle while `out_ready`=1.
- `in_ready` depends only on registered count, with no combinational path from `out_ready`.
- The head payload is stable while `out_valid` & ~`out_ready`.
- `flush` or `reset` asserted in cycle N gives `out_valid`=0 in cycle N+1.

## Structure
- Shared package `ppu_pkg`:
  - Opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR).
  - S-code constants: SEL_PB=0, SEL_IMM_I=1, SEL_IMM_S=2, SEL_IMM_U=3, SEL_PC=4, SEL_ZERO=5. These are shared with the second-operand mux.
  - NOP constant.
- Sub-module `operand_sel_decode`: purely combinational, instruction to {S, immediates, illegal}. The top level holds the FIFO and handshake.

## Test plan
- **Basic decode.** Push 0x00500093 (addi) with `out_ready`=1 → next cycle S=1, imm12_I=0x005, illegal=0.
- **Store and upper-immediate decode.** Push 0xFE112E23 (sw) → S=2, imm12_S=0xFFC. Push 0x123450B7 (lui) → S=3, imm20=0x12345. Push 0x0000006F (jal) → S=4.
- **Backpressure.**
  - Hold `out_ready`=0 and push 3 instructions → `in_ready` drops after 2 pushes; the third is accepted only after the first pop.
  - Order is preserved and the head payload is stable while stalled.
- **Flush priority.** Two entries buffered; assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, count=0, the in-flight instruction is not enqueued.
- **Illegal opcode and bubble.**
  - Push 0x0000007F → S=5, illegal=1.
  - Push 0x00000013 → `in_ready`=1 and no output appears.
- **Reset mid-stream.** One entry buffered; assert `reset` for 1 cycle → `out_valid`=0 with all payload outputs 0; `in_ready`=0 during reset and 1 the cycle after.
